// File: rtl/reg_file_alu_pipeline.sv
// reg_file_alu_pipeline: a single-issue ALU that sits beside a 2R/1W register file.
// Single-cycle ops register their result one edge after acceptance; MUL runs an
// 8-step shift-add sequence and blocks new instructions until it completes.
// The in-flight write is forwarded into the operands so dependent ops can issue
// back to back.
module reg_file_alu_pipeline #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [2:0]       opcode,
    input  logic [2:0]       rs1,
    input  logic [2:0]       rs2,
    input  logic [2:0]       rd,
    input  logic [width-1:0] imm,
    output logic [2:0]       read_port_1,
    output logic [2:0]       read_port_2,
    input  logic [width-1:0] read_data_1,
    input  logic [width-1:0] read_data_2,
    output logic [width-1:0] write_data,
    output logic [2:0]       write_port,
    output logic             write_enable,
    output logic             flag_zero,
    output logic             flag_carry
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_LDI = 3'b111;

    // The last multiplier bit is processed when the counter is about to wrap.
    localparam logic [2:0] MUL_LAST = 3'd7;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_e;

    state_e           state;
    state_e           state_next;
    logic             accept;
    logic [2:0]       mul_count;
    logic [width-1:0] mul_a;
    logic [width-1:0] mul_b;
    logic [width-1:0] mul_acc;
    logic [width-1:0] mul_sum;
    logic [2:0]       mul_rd;
    logic [width-1:0] op_a;
    logic [width-1:0] op_b;
    logic [width:0]   alu_wide;
    logic [width-1:0] alu_result;

    // Read addresses come straight from the instruction fields.
    assign read_port_1 = rs1;
    assign read_port_2 = rs2;

    // Operand select: the write being committed this cycle has not reached the file yet.
    always_comb begin
        op_a = (write_enable && write_port == rs1) ? write_data : read_data_1;
        op_b = (write_enable && write_port == rs2) ? write_data : read_data_2;
    end

    // Single-cycle ALU; the extra top bit carries ADD carry-out / SUB borrow.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        alu_wide = '0;
        case (opcode)
            OP_ADD:  alu_wide = {1'b0, op_a} + {1'b0, op_b};
            OP_SUB:  alu_wide = {1'b0, op_a} - {1'b0, op_b};
            OP_AND:  alu_wide = {1'b0, op_a & op_b};
            OP_OR:   alu_wide = {1'b0, op_a | op_b};
            OP_XOR:  alu_wide = {1'b0, op_a ^ op_b};
            OP_SHL:  alu_wide = {1'b0, op_a << op_b[2:0]};
            OP_LDI:  alu_wide = {1'b0, imm};
            default: alu_wide = '0;
        endcase
        alu_result = alu_wide[width-1:0];
    end

    // One shift-add step: add the multiplicand shifted by the current bit position.
    always_comb begin
        mul_sum = mul_acc + (mul_b[mul_count] ? (mul_a << mul_count) : '0);
    end

    // Next-state and handshake: ready only while idle; MUL leaves idle for eight steps.
    always_comb begin
        state_next  = state;
        instr_ready = 1'b0;
        accept      = 1'b0;
        case (state)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    accept = 1'b1;
                    if (opcode == OP_MUL) begin
                        state_next = S_MUL;
                    end
                end
            end
            S_MUL: begin
                if (mul_count == MUL_LAST) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state <= state_next;
        end
    end

    // Datapath registers: write port, flags and multiplier sequencer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            write_data   <= '0;
            write_port   <= '0;
            write_enable <= 1'b0;
            flag_zero    <= 1'b0;
            flag_carry   <= 1'b0;
            mul_count    <= '0;
            mul_a        <= '0;
            mul_b        <= '0;
            mul_acc      <= '0;
            mul_rd       <= '0;
        end else begin
            write_enable <= 1'b0;
            if (state == S_IDLE) begin
                if (accept && opcode == OP_MUL) begin
                    mul_a     <= op_a;
                    mul_b     <= op_b;
                    mul_rd    <= rd;
                    mul_acc   <= '0;
                    mul_count <= '0;
                end else if (accept) begin
                    write_data   <= alu_result;
                    write_port   <= rd;
                    write_enable <= 1'b1;
                    flag_zero    <= (alu_result == '0);
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        flag_carry <= alu_wide[width];
                    end
                end
            end else begin
                mul_acc   <= mul_sum;
                mul_count <= mul_count + 3'd1;
                if (mul_count == MUL_LAST) begin
                    write_data   <= mul_sum;
                    write_port   <= mul_rd;
                    write_enable <= 1'b1;
                    flag_zero    <= (mul_sum == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_file_alu_pipeline.sv
// Bench for reg_file_alu_pipeline: an 8x8 register file surrounds the DUT, an
// architectural model (sequential execution over a plain array) predicts each
// write, and a monitor compares every write the DUT presents against a queue.
module tb_reg_file_alu_pipeline;

    localparam int W = 8;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_LDI = 3'b111;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         instr_valid = 1'b0;
    logic         instr_ready;
    logic [2:0]   opcode = '0;
    logic [2:0]   rs1 = '0;
    logic [2:0]   rs2 = '0;
    logic [2:0]   rd = '0;
    logic [W-1:0] imm = '0;
    logic [2:0]   read_port_1;
    logic [2:0]   read_port_2;
    logic [W-1:0] read_data_1;
    logic [W-1:0] read_data_2;
    logic [W-1:0] write_data;
    logic [2:0]   write_port;
    logic         write_enable;
    logic         flag_zero;
    logic         flag_carry;

    always #5 clk = ~clk;

    reg_file_alu_pipeline #(.width(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .opcode       (opcode),
        .rs1          (rs1),
        .rs2          (rs2),
        .rd           (rd),
        .imm          (imm),
        .read_port_1  (read_port_1),
        .read_port_2  (read_port_2),
        .read_data_1  (read_data_1),
        .read_data_2  (read_data_2),
        .write_data   (write_data),
        .write_port   (write_port),
        .write_enable (write_enable),
        .flag_zero    (flag_zero),
        .flag_carry   (flag_carry)
    );

    // Register file environment: combinational read, commit on the edge after the strobe.
    logic [W-1:0] rf [8];
    assign read_data_1 = rf[read_port_1];
    assign read_data_2 = rf[read_port_2];
    always @(posedge clk) begin
        if (write_enable) rf[write_port] <= write_data;
    end

    typedef struct packed {
        logic [W-1:0] data;
        logic [2:0]   port;
        logic         zero;
        logic         carry;
    } exp_t;

    exp_t exp_q[$];
    int   model_rf [8];
    bit   model_carry = 1'b0;
    int   check_count = 0;
    int   pass_count  = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    endtask

    // Architectural reference: instructions execute one after another on an int array.
    task automatic model_exec(input logic [2:0] op, input logic [2:0] s1, input logic [2:0] s2,
                              input logic [2:0] d, input logic [W-1:0] im);
        int a, b, r;
        exp_t e;
        a = model_rf[s1];
        b = model_rf[s2];
        case (op)
            3'b000: begin r = a + b; model_carry = (r > 255); r = r % 256; end
            3'b001: begin model_carry = (a < b); r = (a - b + 256) % 256; end
            3'b010: r = a & b;
            3'b011: r = a | b;
            3'b100: r = a ^ b;
            3'b101: r = (a * (1 << (b % 8))) % 256;
            3'b110: r = (a * b) % 256;
            default: r = int'(im);
        endcase
        model_rf[d] = r;
        e.data  = W'(r);
        e.port  = d;
        e.zero  = (r == 0);
        e.carry = model_carry;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; waits (bounded) for ready, presents the instruction for one edge.
    task automatic issue(input logic [2:0] op, input logic [2:0] s1, input logic [2:0] s2,
                         input logic [2:0] d, input logic [W-1:0] im, input bit expect_write = 1'b1);
        int waited = 0;
        while (instr_ready !== 1'b1) begin
            if (waited >= 20) begin
                instr_valid = 1'b0;
                check("ready_timeout", 32'(instr_ready), 1);
                return;
            end
            waited++;
            @(negedge clk);
        end
        instr_valid = 1'b1;
        opcode = op;
        rs1 = s1;
        rs2 = s2;
        rd = d;
        imm = im;
        if (expect_write) model_exec(op, s1, s2, d, im);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        instr_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every write the DUT presents must match the oldest expected write.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && write_enable === 1'b1) begin
                check("write_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("wr_data", 32'(write_data), 32'(e.data));
                    check("wr_port", 32'(write_port), 32'(e.port));
                    check("flag_zero", 32'(flag_zero), 32'(e.zero));
                    check("flag_carry", 32'(flag_carry), 32'(e.carry));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            rf[i] = '0;
            model_rf[i] = 0;
        end

        // Asynchronous reset before any clock edge.
        #1 reset = 1'b0;
        #2;
        check("rst_write_data", 32'(write_data), 0);
        check("rst_write_port", 32'(write_port), 0);
        check("rst_write_enable", 32'(write_enable), 0);
        check("rst_flag_zero", 32'(flag_zero), 0);
        check("rst_flag_carry", 32'(flag_carry), 0);
        check("rst_ready", 32'(instr_ready), 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Dependent chain with forwarding, then borrow, carry and zero cases.
        issue(OP_LDI, 3'd0, 3'd0, 3'd0, 8'd100);
        issue(OP_LDI, 3'd0, 3'd0, 3'd1, 8'd50);
        issue(OP_ADD, 3'd0, 3'd1, 3'd2, 8'd0);
        issue(OP_SUB, 3'd1, 3'd0, 3'd3, 8'd0);
        issue(OP_LDI, 3'd0, 3'd0, 3'd5, 8'd200);
        issue(OP_ADD, 3'd5, 3'd0, 3'd6, 8'd0);
        issue(OP_XOR, 3'd0, 3'd0, 3'd7, 8'd0);
        check("rd_port_1", 32'(read_port_1), 0);

        // MUL r4 = r0 * r1 with a competing instruction held valid during the busy cycles.
        issue(OP_MUL, 3'd0, 3'd1, 3'd4, 8'd0);
        opcode = OP_ADD; rs1 = 3'd2; rs2 = 3'd2; rd = 3'd3;
        for (int i = 0; i < 8; i++) begin
            check("mul_busy_ready", 32'(instr_ready), 0);
            check("mul_busy_we", 32'(write_enable), 0);
            @(negedge clk);
        end
        instr_valid = 1'b0;
        check("mul_done_we", 32'(write_enable), 1);
        check("mul_done_data", 32'(write_data), 136);
        check("mul_done_port", 32'(write_port), 4);
        check("mul_done_ready", 32'(instr_ready), 1);
        idle(2);

        // Reset four edges into a MUL: no write, outputs cleared at once.
        issue(OP_MUL, 3'd5, 3'd6, 3'd4, 8'd0, 1'b0);
        instr_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort_write_data", 32'(write_data), 0);
        check("abort_write_enable", 32'(write_enable), 0);
        check("abort_flag_zero", 32'(flag_zero), 0);
        check("abort_flag_carry", 32'(flag_carry), 0);
        model_carry = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        check("release_ready", 32'(instr_ready), 1);
        idle(1);
        check("abort_r4_kept", 32'(rf[4]), 32'(model_rf[4]));
        issue(OP_ADD, 3'd5, 3'd0, 3'd2, 8'd0);
        idle(1);

        // Randomised instruction stream with occasional bubbles.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 4) == 0) idle(1);
            else issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                       3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
        end
        idle(12);
        check("queue_drained", 32'(exp_q.size()), 0);
        for (int i = 0; i < 8; i++) check("final_rf", 32'(rf[i]), 32'(model_rf[i]));

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
